// File: rtl/dac_sample_queue.sv
// Sample queue feeding the dacx311 driver. Words of {pd, data} are buffered
// in a small FIFO and one word is presented per SPI frame; the queue moves
// on to the next word when the SPI controller's ready signal rises.
module dac_sample_queue #(
   parameter int DEPTH = 8,
   parameter int LW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_pd,
   input  logic [11:0]   in_data,
   input  logic          ready,
   output logic [11:0]   data,
   output logic [1:0]    pd,
   output logic [LW-1:0] level,
   output logic          underrun,
   input  logic          clear_underrun
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   logic [13:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          ready_q;
   logic          advance;
   logic          empty;
   logic          push;
   logic          pop;

   // in_ready depends only on the stored level, so the producer never sees
   // a combinational path from ready or in_valid. A full queue refuses pushes
   // even on a cycle that also pops.
   assign empty    = (level == '0);
   assign in_ready = (level != FULL_LEVEL);
   assign advance  = ready & ~ready_q;
   assign push     = in_valid & in_ready;
   assign pop      = advance & ~empty;

   // Storage array; contents need no reset because pointers and level
   // define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_pd, in_data};
      end
   end

   // Pointers, level, ready edge detector and the registered output word.
   // ready_q resets high so a ready already asserted at reset release is not
   // mistaken for a new frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         ready_q <= 1'b1;
         data    <= 12'h000;
         pd      <= 2'b00;
      end else begin
         ready_q <= ready;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            {pd, data} <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Sticky underrun: a frame advanced with nothing queued. A new underrun
   // takes priority over a simultaneous clear request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         underrun <= 1'b0;
      end else if (advance && empty) begin
         underrun <= 1'b1;
      end else if (clear_underrun) begin
         underrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dac_sample_queue.sv
// Directed bench for dac_sample_queue: reset behaviour, basic push/advance,
// full and empty boundaries, underrun handling, ordered ramp traffic across
// pointer wrap, and asynchronous reset in the middle of operation.
module tb_dac_sample_queue;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_pd;
   logic [11:0] in_data;
   logic        ready;
   logic [11:0] data;
   logic [1:0]  pd;
   logic [3:0]  level;
   logic        underrun;
   logic        clear_underrun;

   int checks;
   int failures;

   dac_sample_queue #(.DEPTH(8), .LW(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_pd          (in_pd),
      .in_data        (in_data),
      .ready          (ready),
      .data           (data),
      .pd             (pd),
      .level          (level),
      .underrun       (underrun),
      .clear_underrun (clear_underrun)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then return 1 time unit after the rising edge.
   task automatic applyStimulus(input logic v, input logic [1:0] p, input logic [11:0] d,
                                input logic r, input logic c);
      in_valid       = v;
      in_pd          = p;
      in_data        = d;
      ready          = r;
      clear_underrun = c;
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Directed test sequence.
   initial begin
      int sent;
      int recv;
      int maxLevel;
      logic rdy;
      logic prevRdy;
      logic pushOk;

      checks         = 0;
      failures       = 0;
      reset          = 1'b1;
      in_valid       = 1'b0;
      in_pd          = 2'b00;
      in_data        = 12'h000;
      ready          = 1'b0;
      clear_underrun = 1'b0;

      @(posedge clk);
      #1;
      checkOutput("rst_data", 16'(data), 16'h000);
      checkOutput("rst_pd", 16'(pd), 16'h0);
      checkOutput("rst_level", 16'(level), 16'h0);
      checkOutput("rst_underrun", 16'(underrun), 16'h0);
      checkOutput("rst_in_ready", 16'(in_ready), 16'h1);
      reset = 1'b0;

      // Two words, two ready pulses.
      applyStimulus(1'b1, 2'b00, 12'hfff, 1'b0, 1'b0);
      checkOutput("b_level1", 16'(level), 16'h1);
      applyStimulus(1'b1, 2'b00, 12'h123, 1'b0, 1'b0);
      checkOutput("b_level2", 16'(level), 16'h2);
      checkOutput("b_data_hold", 16'(data), 16'h000);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
      checkOutput("b_data_fff", 16'(data), 16'hfff);
      checkOutput("b_frame1", {pd, data, 2'b00}, 16'h3ffc);
      checkOutput("b_level_1", 16'(level), 16'h1);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
      checkOutput("b_data_123", 16'(data), 16'h123);
      checkOutput("b_frame2", {pd, data, 2'b00}, 16'h048c);
      checkOutput("b_level_0", 16'(level), 16'h0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
      checkOutput("b_hold_high_data", 16'(data), 16'h123);
      checkOutput("b_hold_high_underrun", 16'(underrun), 16'h0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);

      // Fill to DEPTH, refuse extra push, one advance frees a slot.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 2'b00, 12'h100 + 12'(i), 1'b0, 1'b0);
      end
      checkOutput("f_level8", 16'(level), 16'h8);
      checkOutput("f_in_ready0", 16'(in_ready), 16'h0);
      checkOutput("f_data_hold", 16'(data), 16'h123);
      applyStimulus(1'b1, 2'b00, 12'habc, 1'b0, 1'b0);
      checkOutput("f_refused_level", 16'(level), 16'h8);
      applyStimulus(1'b1, 2'b00, 12'hdef, 1'b1, 1'b0);
      checkOutput("f_pop_data", 16'(data), 16'h100);
      checkOutput("f_pop_level", 16'(level), 16'h7);
      checkOutput("f_in_ready1", 16'(in_ready), 16'h1);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);
      for (int i = 1; i < 8; i++) begin
         applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
         checkOutput("f_drain_data", 16'(data), 16'h100 + 16'(i));
         applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);
      end
      checkOutput("f_drained_level", 16'(level), 16'h0);

      // Underrun set, clear, and set winning over clear.
      applyStimulus(1'b1, 2'b00, 12'h555, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
      checkOutput("u_data555", 16'(data), 16'h555);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);
      checkOutput("u_none_yet", 16'(underrun), 16'h0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
      checkOutput("u_set", 16'(underrun), 16'h1);
      checkOutput("u_data_hold", 16'(data), 16'h555);
      checkOutput("u_level0", 16'(level), 16'h0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 1'b1);
      checkOutput("u_cleared", 16'(underrun), 16'h0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b1);
      checkOutput("u_set_wins", 16'(underrun), 16'h1);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);
      checkOutput("u_sticky", 16'(underrun), 16'h1);

      // Simultaneous push and advance, empty and non-empty.
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 1'b1);
      checkOutput("s_pre_clear", 16'(underrun), 16'h0);
      applyStimulus(1'b1, 2'b01, 12'h2a1, 1'b1, 1'b0);
      checkOutput("s0_underrun", 16'(underrun), 16'h1);
      checkOutput("s0_data_hold", 16'(data), 16'h555);
      checkOutput("s0_pd_hold", 16'(pd), 16'h0);
      checkOutput("s0_level1", 16'(level), 16'h1);
      applyStimulus(1'b1, 2'b11, 12'h3b2, 1'b0, 1'b1);
      checkOutput("s_clear2", 16'(underrun), 16'h0);
      applyStimulus(1'b1, 2'b00, 12'h4c3, 1'b0, 1'b0);
      checkOutput("s3_level3", 16'(level), 16'h3);
      applyStimulus(1'b1, 2'b11, 12'h5d4, 1'b1, 1'b0);
      checkOutput("s3_data", 16'(data), 16'h2a1);
      checkOutput("s3_pd01", 16'(pd), 16'h1);
      checkOutput("s3_level_same", 16'(level), 16'h3);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
      checkOutput("s_word2", {pd, 2'b00, data}, 16'hc3b2);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
      checkOutput("s_word3", {pd, 2'b00, data}, 16'h04c3);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
      checkOutput("s_word4", {pd, 2'b00, data}, 16'hc5d4);
      checkOutput("s_level_end", 16'(level), 16'h0);
      checkOutput("s_no_underrun", 16'(underrun), 16'h0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);

      // Ramp 0..23 with continuous producer and ready toggling every 20 cycles.
      sent     = 0;
      recv     = 0;
      maxLevel = 0;
      prevRdy  = 1'b0;
      for (int cyc = 0; cyc < 960; cyc++) begin
         rdy    = ((cyc / 20) % 2) == 1;
         pushOk = (sent < 24) && in_ready;
         applyStimulus(sent < 24, 2'b00, 12'(sent), rdy, 1'b0);
         if (pushOk) sent++;
         if (rdy && !prevRdy) begin
            checkOutput("ramp_data", 16'(data), 16'(recv));
            recv++;
         end
         if (int'(level) > maxLevel) maxLevel = int'(level);
         prevRdy = rdy;
      end
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);
      checkOutput("ramp_recv", 16'(recv), 16'd24);
      checkOutput("ramp_level_max", 16'(maxLevel), 16'd8);
      checkOutput("ramp_level_end", 16'(level), 16'h0);
      checkOutput("ramp_underrun", 16'(underrun), 16'h0);

      // Asynchronous reset mid-operation, ready held high through release.
      applyStimulus(1'b1, 2'b00, 12'h0a0, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 2'b10, 12'(i), 1'b0, 1'b0);
      end
      checkOutput("r_data0a0", 16'(data), 16'h0a0);
      checkOutput("r_level5", 16'(level), 16'h5);
      in_valid = 1'b0;
      reset    = 1'b1;
      #1;
      checkOutput("r_async_level", 16'(level), 16'h0);
      checkOutput("r_async_data", 16'(data), 16'h000);
      checkOutput("r_async_in_ready", 16'(in_ready), 16'h1);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
      reset = 1'b0;
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
      checkOutput("r_no_adv_underrun", 16'(underrun), 16'h0);
      checkOutput("r_no_adv_data", 16'(data), 16'h000);
      applyStimulus(1'b1, 2'b00, 12'h777, 1'b0, 1'b0);
      checkOutput("r_post_level", 16'(level), 16'h1);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b1, 1'b0);
      checkOutput("r_post_data", 16'(data), 16'h777);
      checkOutput("r_post_level0", 16'(level), 16'h0);
      checkOutput("r_post_underrun", 16'(underrun), 16'h0);
      applyStimulus(1'b0, 2'b00, 12'h000, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
